uart_tx_serializer: RTL and testbench

Transmit-side UART framer for the serial link. It takes bytes over a valid/ready handshake and stores one byte in a holding register. It then serializes each byte as start, 8 data bits LSB-first, optional parity and 1–2 stop bits onto `tx`, one bit per `tick` pulse. It shares the bit-rate tick generator style with the receive path and supports back-to-back frames with no idle gap.

---
 rtl/uart_tx_serializer.sv | 156 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit framer: one-byte holding register feeding a tick-paced shifter
// that emits start, 8 data bits LSB-first, optional parity and 1-2 stop bits.
`timescale 1ns/1ps
module uart_tx_serializer #(
    parameter int CLK_FREQ_HZ = 1_600_000,
    parameter int BAUD_RATE   = 100_000,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       frame_done,
    output logic       busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic PAR_EN   = (PARITY_EN != 0);
    localparam logic PAR_ODD  = (PARITY_ODD != 0);
    localparam logic TWO_STOP = (STOP_BITS == 2);

    // The rate parameters only describe the expected tick rate; no logic derives from them.
    if (BAUD_RATE <= 0 || CLK_FREQ_HZ < BAUD_RATE) begin : g_rate_doc
    end

    state_t     r_state, w_state_next;
    logic [7:0] r_shift, w_shift_next;
    logic [2:0] r_bit_idx, w_bit_idx_next;
    logic       r_stop_cnt, w_stop_cnt_next;
    logic       r_parity, w_parity_next;
    logic [7:0] r_hold_data, w_hold_data_next;
    logic       r_hold_full, w_hold_full_next;
    logic       r_tx, w_tx_next;
    logic       r_frame_done, w_frame_done_next;
    logic       w_load;
    logic       w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_stop_cnt   <= 1'b0;
            r_parity     <= 1'b0;
            r_hold_data  <= '0;
            r_hold_full  <= 1'b0;
            r_tx         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_idx    <= w_bit_idx_next;
            r_stop_cnt   <= w_stop_cnt_next;
            r_parity     <= w_parity_next;
            r_hold_data  <= w_hold_data_next;
            r_hold_full  <= w_hold_full_next;
            r_tx         <= w_tx_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_bit_idx_next    = r_bit_idx;
        w_stop_cnt_next   = r_stop_cnt;
        w_parity_next     = r_parity;
        w_hold_data_next  = r_hold_data;
        w_hold_full_next  = r_hold_full;
        w_tx_next         = r_tx;
        w_frame_done_next = 1'b0;
        w_load            = 1'b0;
        w_accept          = tx_valid && !r_hold_full;

        if (tick) begin
            case (r_state)
                S_IDLE: begin
                    w_load = r_hold_full;
                end
                S_START: begin
                    w_state_next   = S_DATA;
                    w_tx_next      = r_shift[0];
                    w_bit_idx_next = 3'd0;
                end
                S_DATA: begin
                    if (r_bit_idx != 3'd7) begin
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_tx_next      = r_shift[1];
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end else if (PAR_EN) begin
                        w_state_next = S_PARITY;
                        w_tx_next    = r_parity;
                    end else begin
                        w_state_next    = S_STOP;
                        w_tx_next       = 1'b1;
                        w_stop_cnt_next = 1'b0;
                    end
                end
                S_PARITY: begin
                    w_state_next    = S_STOP;
                    w_tx_next       = 1'b1;
                    w_stop_cnt_next = 1'b0;
                end
                S_STOP: begin
                    if (r_stop_cnt == TWO_STOP) begin
                        w_frame_done_next = 1'b1;
                        w_stop_cnt_next   = 1'b0;
                        // A held byte starts its frame without an idle bit in between.
                        if (r_hold_full) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_next = S_IDLE;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_stop_cnt_next = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_tx_next    = 1'b1;
                end
            endcase
        end

        // Load only happens while the holding register is full, so tx_ready is
        // low and a new handshake cannot collide with it.
        if (w_load) begin
            w_state_next     = S_START;
            w_shift_next     = r_hold_data;
            w_parity_next    = (^r_hold_data) ^ PAR_ODD;
            w_tx_next        = 1'b0;
            w_hold_full_next = 1'b0;
        end else if (w_accept) begin
            w_hold_full_next = 1'b1;
            w_hold_data_next = tx_data;
        end
    end

    assign tx_ready   = !r_hold_full;
    assign tx         = r_tx;
    assign frame_done = r_frame_done;
    assign busy       = (r_state != S_IDLE) || r_hold_full;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances cover 8N1, odd/even
// parity and two stop bits; the line is sampled every clock (16 per bit).
`timescale 1ns/1ps
module tb_uart_tx_serializer;
    localparam int RX_LIMIT = 4000;
    localparam int TX_LIMIT = 4000;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       tx_valid   [4];
    logic [7:0] tx_data    [4];
    logic       tx_ready   [4];
    logic       tx         [4];
    logic       frame_done [4];
    logic       busy       [4];

    int checks = 0;
    int errors = 0;
    int fd_cnt [4] = '{default: 0};
    int phase = 0;

    logic [7:0]  pb   [3] = '{8'h07, 8'h07, 8'hFF};
    logic [31:0] pexp [3] = '{32'h40E, 32'h60E, 32'h7FE};
    logic [7:0]  lb   [256];

    // Instance 0: 8N1, 1: odd parity, 2: even parity, 3: no parity + 2 stop bits.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        uart_tx_serializer #(
            .CLK_FREQ_HZ(1_600_000),
            .BAUD_RATE  (100_000),
            .PARITY_EN  ((gi == 1 || gi == 2) ? 1 : 0),
            .PARITY_ODD ((gi == 1) ? 1 : 0),
            .STOP_BITS  ((gi == 3) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .tx_valid  (tx_valid[gi]),
            .tx_data   (tx_data[gi]),
            .tx_ready  (tx_ready[gi]),
            .tx        (tx[gi]),
            .frame_done(frame_done[gi]),
            .busy      (busy[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running tick, one clock in every 16.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = (phase == 15);
            phase = (phase + 1) % 16;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (frame_done[i] === 1'b1) fd_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int i, input logic [7:0] b);
        int n;
        n = 0;
        tx_valid[i] = 1'b1;
        tx_data[i]  = b;
        while (tx_ready[i] !== 1'b1 && n < TX_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("tx_handshake", n < TX_LIMIT, 1'b1);
        @(negedge clk);
        tx_valid[i] = 1'b0;
        tx_data[i]  = ~b;
    endtask

    task automatic capture(input int i, input int nbits, output logic [31:0] frm,
                           output logic rdy_mid, output int waited);
        int   unstable;
        logic lvl;
        unstable = 0;
        waited   = 0;
        frm      = '0;
        rdy_mid  = 1'bx;
        while (tx[i] !== 1'b0 && waited < RX_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check("rx_start_seen", waited < RX_LIMIT, 1'b1);
        for (int k = 0; k < 16 * nbits; k++) begin
            if (k > 0) @(negedge clk);
            lvl = tx[i];
            if (k % 16 == 0) frm[k / 16] = lvl;
            else if (lvl !== frm[k / 16]) unstable++;
            if (k == 80) rdy_mid = tx_ready[i];
        end
        check("rx_bit_stable", unstable, 0);
        $display("rx inst=%0d bits=%0d frame=%h", i, nbits, frm);
    endtask

    task automatic snap(input int i, output int v);
        @(negedge clk);
        #1 v = fd_cnt[i];
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] frm;
        logic        rd;
        int          w;
        int          n;
        int          f0;
        int          low;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'h00;
        end
        for (int j = 0; j < 256; j++) lb[j] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("rst_tx", tx[0], 1'b1);
        check("rst_ready", tx_ready[0], 1'b1);
        check("rst_busy", busy[0], 1'b0);
        check("rst_done", frame_done[0], 1'b0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // 0x55, 8N1: alternating levels, 16 clocks each.
        snap(0, f0);
        fork
            send(0, 8'h55);
            capture(0, 10, frm, rd, w);
        join
        check("t1_frame", frm, 32'h2AA);
        check("t1_ready_mid", rd, 1'b1);
        check("t1_busy_stop", busy[0], 1'b1);
        @(negedge clk);
        check("t1_done", frame_done[0], 1'b1);
        check("t1_busy_end", busy[0], 1'b0);
        check("t1_tx_idle", tx[0], 1'b1);
        @(negedge clk);
        check("t1_done_pulse", frame_done[0], 1'b0);
        #1 check("t1_done_cnt", fd_cnt[0] - f0, 1);

        // Handshake on a tick cycle: that tick must not start the frame.
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (tick !== 1'b1 && n < 64);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h81;
        @(posedge clk);
        #1 tx_valid[0] = 1'b0;
        n = 0;
        while (tx[0] !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("latency_clks", n, 17);
        repeat (200) @(negedge clk);
        check("latency_idle", busy[0], 1'b0);

        // Back-to-back 0xA5, 0x3C with valid effectively held high.
        snap(0, f0);
        fork
            begin
                send(0, 8'hA5);
                send(0, 8'h3C);
            end
            capture(0, 20, frm, rd, w);
        join
        check("b2b_frames", frm, 32'h9E34A);
        check("b2b_ready_mid", rd, 1'b0);
        @(negedge clk);
        check("b2b_done", frame_done[0], 1'b1);
        check("b2b_tx_idle", tx[0], 1'b1);
        #1 check("b2b_done_cnt", fd_cnt[0] - f0, 2);

        // Odd parity 0x07, even parity 0x07, two stop bits 0xFF.
        for (int t = 0; t < 3; t++) begin
            snap(t + 1, f0);
            fork
                send(t + 1, pb[t]);
                capture(t + 1, 11, frm, rd, w);
            join
            check("var_frame", frm, pexp[t]);
            @(negedge clk);
            check("var_done", frame_done[t + 1], 1'b1);
            #1 check("var_done_cnt", fd_cnt[t + 1] - f0, 1);
        end

        // Reset during data bit 3 of 0x96 while 0x5A is held.
        repeat (20) @(negedge clk);
        fork
            begin
                send(0, 8'h96);
                send(0, 8'h5A);
            end
            begin
                n = 0;
                while (tx[0] !== 1'b0 && n < RX_LIMIT) begin
                    @(negedge clk);
                    n++;
                end
                check("rst_mid_start", n < RX_LIMIT, 1'b1);
                repeat (16 * 4 + 8) @(negedge clk);
            end
        join
        check("rst_mid_held", tx_ready[0], 1'b0);
        check("rst_mid_bit3", tx[0], 1'b0);
        #1 f0 = fd_cnt[0];
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx[0], 1'b1);
        check("rst_mid_ready", tx_ready[0], 1'b1);
        check("rst_mid_busy", busy[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        low = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) low++;
        end
        check("rst_mid_quiet", low, 0);
        check("rst_mid_idle", busy[0], 1'b0);
        #1 check("rst_mid_no_done", fd_cnt[0] - f0, 0);

        @(negedge clk);
        fork
            send(0, 8'h3A);
            capture(0, 10, frm, rd, w);
        join
        check("rst_fresh_frame", frm, 32'h274);
        repeat (20) @(negedge clk);

        // Loopback: 256 random bytes, contiguous frames.
        snap(0, f0);
        fork
            begin
                for (int j = 0; j < 256; j++) send(0, lb[j]);
            end
            begin
                for (int j = 0; j < 256; j++) begin
                    capture(0, 10, frm, rd, w);
                    check("loop_data", frm, {22'd0, 1'b1, lb[j], 1'b0});
                    if (j > 0) check("loop_gap", w, 1);
                end
            end
        join
        repeat (20) @(negedge clk);
        #1 check("loop_done_cnt", fd_cnt[0] - f0, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
